// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, ALU commands,
// branch types and the FSM state enum.
package ctrl_pkg;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000011;
  localparam logic [5:0] OP_AND  = 6'b000101;
  localparam logic [5:0] OP_OR   = 6'b000110;
  localparam logic [5:0] OP_NOR  = 6'b000111;
  localparam logic [5:0] OP_XOR  = 6'b001000;
  localparam logic [5:0] OP_SLA  = 6'b001001;
  localparam logic [5:0] OP_SLL  = 6'b001010;
  localparam logic [5:0] OP_SRA  = 6'b001011;
  localparam logic [5:0] OP_SRL  = 6'b001100;
  localparam logic [5:0] OP_ADDI = 6'b100000;
  localparam logic [5:0] OP_SUBI = 6'b100001;
  localparam logic [5:0] OP_LD   = 6'b100100;
  localparam logic [5:0] OP_ST   = 6'b100101;
  localparam logic [5:0] OP_BEZ  = 6'b101000;
  localparam logic [5:0] OP_BNE  = 6'b101001;
  localparam logic [5:0] OP_JMP  = 6'b101010;

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SHL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SRL = 4'b1010;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder: ALU command, operand selects, branch type
// and instruction class. Unknown opcodes decode to all-zero with legal=0.
module instr_decoder
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned CMD_W    = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [CMD_W-1:0]    exec_cmd,
  output logic                is_imm,
  output logic                single_src,
  output logic [1:0]          branch_type,
  output logic                is_ld,
  output logic                is_st,
  output logic                is_alu,
  output logic                legal
);

  logic       hi_zero;
  logic [3:0] cmd;
  logic       known;

  // Bits above the 6-bit opcode field must be clear for a legal opcode
  if (OPCODE_W > 6) begin : g_hi
    assign hi_zero = ~|opcode[OPCODE_W-1:6];
  end else begin : g_nohi
    assign hi_zero = 1'b1;
  end

  // Opcode table lookup
  always_comb begin
    cmd         = CMD_ADD;
    is_imm      = 1'b0;
    single_src  = 1'b0;
    branch_type = BR_NONE;
    is_ld       = 1'b0;
    is_st       = 1'b0;
    is_alu      = 1'b0;
    known       = 1'b1;
    unique case (opcode[5:0])
      OP_NOP:  ;
      OP_ADD:  is_alu = 1'b1;
      OP_SUB:  begin cmd = CMD_SUB; is_alu = 1'b1; end
      OP_AND:  begin cmd = CMD_AND; is_alu = 1'b1; end
      OP_OR:   begin cmd = CMD_OR;  is_alu = 1'b1; end
      OP_NOR:  begin cmd = CMD_NOR; is_alu = 1'b1; end
      OP_XOR:  begin cmd = CMD_XOR; is_alu = 1'b1; end
      OP_SLA,
      OP_SLL:  begin cmd = CMD_SHL; is_alu = 1'b1; single_src = 1'b1; end
      OP_SRA:  begin cmd = CMD_SRA; is_alu = 1'b1; single_src = 1'b1; end
      OP_SRL:  begin cmd = CMD_SRL; is_alu = 1'b1; single_src = 1'b1; end
      OP_ADDI: begin is_alu = 1'b1; is_imm = 1'b1; end
      OP_SUBI: begin cmd = CMD_SUB; is_alu = 1'b1; is_imm = 1'b1; end
      OP_LD:   begin is_ld = 1'b1; is_imm = 1'b1; end
      OP_ST:   begin is_st = 1'b1; is_imm = 1'b1; end
      OP_BEZ:  branch_type = BR_BEZ;
      OP_BNE:  branch_type = BR_BNE;
      OP_JMP:  branch_type = BR_JMP;
      default: known = 1'b0;
    endcase
    legal = known & hi_zero;
    if (!legal) begin
      cmd         = CMD_ADD;
      is_imm      = 1'b0;
      single_src  = 1'b0;
      branch_type = BR_NONE;
      is_ld       = 1'b0;
      is_st       = 1'b0;
      is_alu      = 1'b0;
    end
    exec_cmd = CMD_W'(cmd);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS sequencing control: FETCH/DECODE/EXEC/MEM/WB FSM with a
// memory ready handshake, branch qualification, sticky error flags and a
// retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned CMD_W       = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                br_cond,
  output logic [2:0]          state,
  output logic                iord,
  output logic                mem_r_en,
  output logic                mem_w_en,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic [CMD_W-1:0]    exec_cmd,
  output logic                is_imm,
  output logic                single_src,
  output logic [1:0]          branch_type,
  output logic                wb_en,
  output logic                illegal_op,
  output logic                bus_err,
  output logic [CNT_W-1:0]    retired
);

  localparam int unsigned WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_t            cur;
  logic              ld_q;
  logic              st_q;
  logic [WAIT_W-1:0] wait_cnt;

  logic [CMD_W-1:0]  dec_cmd;
  logic              dec_imm;
  logic              dec_single;
  logic [1:0]        dec_branch;
  logic              dec_ld;
  logic              dec_st;
  logic              dec_alu;
  logic              dec_legal;
  logic              dec_nop;

  logic              mem_wait;
  logic              timeout;
  logic              retire;

  instr_decoder #(
    .OPCODE_W (OPCODE_W),
    .CMD_W    (CMD_W)
  ) u_dec (
    .opcode      (opcode),
    .exec_cmd    (dec_cmd),
    .is_imm      (dec_imm),
    .single_src  (dec_single),
    .branch_type (dec_branch),
    .is_ld       (dec_ld),
    .is_st       (dec_st),
    .is_alu      (dec_alu),
    .legal       (dec_legal)
  );

  assign dec_nop = dec_legal & ~dec_alu & ~dec_ld & ~dec_st & (dec_branch == BR_NONE);
  assign state   = cur;

  // Wait-cycle detection, timeout and retire qualification
  always_comb begin
    mem_wait = ((cur == FETCH) && en && !mem_ready) || ((cur == MEM) && !mem_ready);
    timeout  = (MEM_TIMEOUT != 0) && mem_wait && (wait_cnt == WAIT_W'(TO_LAST));
    retire   = 1'b0;
    case (cur)
      DECODE:  retire = !dec_legal || dec_nop;
      EXEC:    retire = (branch_type != BR_NONE);
      MEM:     retire = mem_ready && st_q;
      WB:      retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  // Strobes decode from the registered state so zero-wait memory completes in one cycle
  always_comb begin
    iord     = 1'b0;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = 1'b0;
    wb_en    = 1'b0;
    case (cur)
      FETCH: begin
        if (en) begin
          mem_r_en = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
      end
      EXEC: begin
        if (branch_type != BR_NONE) begin
          pc_write = (branch_type == BR_JMP) || br_cond;
          pc_src   = 1'b1;
        end
      end
      MEM: begin
        iord     = 1'b1;
        mem_r_en = ld_q;
        mem_w_en = st_q;
      end
      WB:      wb_en = 1'b1;
      default: ;
    endcase
  end

  // FSM, decoded-field registers, wait counter, sticky flags and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= FETCH;
      exec_cmd    <= '0;
      is_imm      <= 1'b0;
      single_src  <= 1'b0;
      branch_type <= BR_NONE;
      ld_q        <= 1'b0;
      st_q        <= 1'b0;
      illegal_op  <= 1'b0;
      bus_err     <= 1'b0;
      retired     <= '0;
      wait_cnt    <= '0;
    end else begin
      if (timeout) begin
        wait_cnt <= '0;
        bus_err  <= 1'b1;
      end else if (mem_wait) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (retire) retired <= retired + 1'b1;

      case (cur)
        FETCH: if (en && mem_ready) cur <= DECODE;
        DECODE: begin
          exec_cmd    <= dec_cmd;
          is_imm      <= dec_imm;
          single_src  <= dec_single;
          branch_type <= dec_branch;
          ld_q        <= dec_ld;
          st_q        <= dec_st;
          if (!dec_legal) illegal_op <= 1'b1;
          cur <= (!dec_legal || dec_nop) ? FETCH : EXEC;
        end
        EXEC: begin
          if (branch_type != BR_NONE) cur <= FETCH;
          else if (ld_q || st_q)      cur <= MEM;
          else                        cur <= WB;
        end
        MEM: begin
          if (mem_ready)    cur <= ld_q ? WB : FETCH;
          else if (timeout) cur <= FETCH;
        end
        WB:      cur <= FETCH;
        default: cur <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and strobe vectors
// with hand-computed expectations, small retire counter to reach wrap.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;

  // strobe vector order: {iord, mem_r_en, mem_w_en, ir_write, pc_write, pc_src, wb_en}
  localparam logic [6:0] S_NONE  = 7'b0000000;
  localparam logic [6:0] S_FET   = 7'b0101100;
  localparam logic [6:0] S_FWAIT = 7'b0100000;
  localparam logic [6:0] S_MRD   = 7'b1100000;
  localparam logic [6:0] S_MWR   = 7'b1010000;
  localparam logic [6:0] S_BRT   = 7'b0000110;
  localparam logic [6:0] S_BRN   = 7'b0000010;
  localparam logic [6:0] S_WB    = 7'b0000001;

  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             br_cond;
  logic [2:0]       state;
  logic             iord, mem_r_en, mem_w_en, ir_write, pc_write, pc_src;
  logic [3:0]       exec_cmd;
  logic             is_imm, single_src, wb_en, illegal_op, bus_err;
  logic [1:0]       branch_type;
  logic [CNT_W-1:0] retired;
  logic [6:0]       strb;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  logic [5:0] t_op  [10] = '{6'b000011, 6'b001000, 6'b001010, 6'b001011, 6'b100001,
                             6'b000111, 6'b000110, 6'b000101, 6'b001100, 6'b001001};
  logic [3:0] t_cmd [10] = '{4'h2, 4'h7, 4'h8, 4'h9, 4'h2, 4'h6, 4'h5, 4'h4, 4'hA, 4'h8};
  logic       t_imm [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
  logic       t_sh  [10] = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 1};

  multicycle_ctrl #(
    .OPCODE_W    (6),
    .CMD_W       (4),
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .br_cond     (br_cond),
    .state       (state),
    .iord        (iord),
    .mem_r_en    (mem_r_en),
    .mem_w_en    (mem_w_en),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .exec_cmd    (exec_cmd),
    .is_imm      (is_imm),
    .single_src  (single_src),
    .branch_type (branch_type),
    .wb_en       (wb_en),
    .illegal_op  (illegal_op),
    .bus_err     (bus_err),
    .retired     (retired)
  );

  assign strb = {iord, mem_r_en, mem_w_en, ir_write, pc_write, pc_src, wb_en};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, check, advance.
  task automatic cyc(input string tag, input logic e, input logic [5:0] op, input logic rdy,
                     input logic bc, input logic [2:0] st, input logic [6:0] sb);
    en = e; opcode = op; mem_ready = rdy; br_cond = bc;
    #1;
    check({tag, "/state"}, 32'(state), 32'(st));
    check({tag, "/strb"}, 32'(strb), 32'(sb));
    @(negedge clk);
  endtask

  task automatic chk_ret(input string tag);
    check({tag, "/retired"}, 32'(retired), 32'(exp_ret % 16));
  endtask

  task automatic run_alu(input string tag, input logic [5:0] op, input logic [3:0] cmd,
                         input logic imm, input logic sh);
    cyc({tag, "_f"}, 1, op, 1, 0, F, S_FET);
    cyc({tag, "_d"}, 1, op, 1, 0, D, S_NONE);
    check({tag, "/cmd"}, 32'(exec_cmd), 32'(cmd));
    check({tag, "/imm"}, 32'(is_imm), 32'(imm));
    check({tag, "/single"}, 32'(single_src), 32'(sh));
    check({tag, "/bt"}, 32'(branch_type), 0);
    cyc({tag, "_e"}, 1, op, 1, 0, E, S_NONE);
    cyc({tag, "_w"}, 1, op, 1, 0, W, S_WB);
    exp_ret++;
    chk_ret(tag);
  endtask

  task automatic run_br(input string tag, input logic [5:0] op, input logic bc,
                        input logic [1:0] bt, input logic [6:0] sb);
    cyc({tag, "_f"}, 1, op, 1, 0, F, S_FET);
    cyc({tag, "_d"}, 1, op, 1, 0, D, S_NONE);
    check({tag, "/bt"}, 32'(branch_type), 32'(bt));
    cyc({tag, "_e"}, 1, op, 1, bc, E, sb);
    exp_ret++;
    chk_ret(tag);
  endtask

  initial begin
    rst = 1; en = 0; opcode = '0; mem_ready = 0; br_cond = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("rst/state", 32'(state), 0);
    check("rst/strb", 32'(strb), 0);
    check("rst/retired", 32'(retired), 0);
    check("rst/flags", 32'({illegal_op, bus_err}), 0);
    check("rst/dec", 32'({exec_cmd, is_imm, single_src, branch_type}), 0);
    @(negedge clk);

    // idle with en=0: mem_ready is ignored
    cyc("idle", 0, 6'b000000, 1, 0, F, S_NONE);
    cyc("idle2", 0, 6'b000000, 1, 0, F, S_NONE);

    // NOP: two cycles
    cyc("nop_f", 1, 6'b000000, 1, 0, F, S_FET);
    cyc("nop_d", 1, 6'b000000, 1, 0, D, S_NONE);
    exp_ret++;
    chk_ret("nop");

    run_alu("add", 6'b000001, 4'h0, 0, 0);

    // LD with two data wait cycles
    cyc("ld_f", 1, 6'b100100, 1, 0, F, S_FET);
    cyc("ld_d", 1, 6'b100100, 1, 0, D, S_NONE);
    check("ld/cmd", 32'(exec_cmd), 0);
    check("ld/imm", 32'(is_imm), 1);
    cyc("ld_e", 1, 6'b100100, 1, 0, E, S_NONE);
    cyc("ld_m1", 1, 6'b100100, 0, 0, M, S_MRD);
    cyc("ld_m2", 0, 6'b100100, 0, 0, M, S_MRD);
    cyc("ld_m3", 0, 6'b100100, 1, 0, M, S_MRD);
    cyc("ld_w", 1, 6'b100100, 1, 0, W, S_WB);
    exp_ret++;
    chk_ret("ld");
    check("ld/bus_err", 32'(bus_err), 0);

    run_br("bez", 6'b101000, 0, 2'b01, S_BRN);
    run_br("bne", 6'b101001, 1, 2'b10, S_BRT);
    run_br("jmp", 6'b101010, 0, 2'b11, S_BRT);

    // illegal opcode: retires from DECODE, flag sticks
    check("pre_ill/flag", 32'(illegal_op), 0);
    cyc("ill_f", 1, 6'b111111, 1, 0, F, S_FET);
    cyc("ill_d", 1, 6'b111111, 1, 0, D, S_NONE);
    exp_ret++;
    chk_ret("ill");
    check("ill/flag", 32'(illegal_op), 1);
    run_alu("add2", 6'b000001, 4'h0, 0, 0);
    check("ill/held", 32'(illegal_op), 1);

    for (int i = 0; i < 10; i++)
      run_alu($sformatf("alu%0d", i), t_op[i], t_cmd[i], t_imm[i], t_sh[i]);

    // ST with memory stuck: abort after four wait cycles
    cyc("st_f", 1, 6'b100101, 1, 0, F, S_FET);
    cyc("st_d", 1, 6'b100101, 1, 0, D, S_NONE);
    check("st/imm", 32'(is_imm), 1);
    cyc("st_e", 1, 6'b100101, 0, 0, E, S_NONE);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("st_m%0d/bus_err", i), 32'(bus_err), 0);
      cyc($sformatf("st_m%0d", i), 1, 6'b100101, 0, 0, M, S_MWR);
    end
    check("st/bus_err", 32'(bus_err), 1);
    chk_ret("st_abort");

    // fetch with one wait cycle after the abort, then a NOP
    cyc("fw_f1", 1, 6'b000000, 0, 0, F, S_FWAIT);
    cyc("fw_f2", 1, 6'b000000, 1, 0, F, S_FET);
    cyc("fw_d", 1, 6'b000000, 1, 0, D, S_NONE);
    exp_ret++;
    chk_ret("fw_nop");
    check("fw/bus_err", 32'(bus_err), 1);

    // reset while in WB of a SUBI
    cyc("rw_f", 1, 6'b100001, 1, 0, F, S_FET);
    cyc("rw_d", 1, 6'b100001, 1, 0, D, S_NONE);
    cyc("rw_e", 1, 6'b100001, 1, 0, E, S_NONE);
    check("rw/cmd", 32'(exec_cmd), 2);
    rst = 1;
    cyc("rw_w", 1, 6'b100001, 1, 0, W, S_WB);
    rst = 0; en = 0;
    #1;
    check("rw/state", 32'(state), 0);
    check("rw/strb", 32'(strb), 0);
    check("rw/retired", 32'(retired), 0);
    check("rw/flags", 32'({illegal_op, bus_err}), 0);
    check("rw/dec", 32'({exec_cmd, is_imm, single_src, branch_type}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
